fb_rect_writer: RTL and testbench

- Avalon-MM write master that fills a rectangle in the VGA framebuffer with one 6-bit colour index. It is the initiator side of the framebuffer pixel-write interface.
- Sits between the game-logic command source (note/fret renderer) and the framebuffer slave.
- Converts one rectangle command into a raster-ordered stream of single-pixel write words: {9'b0, 17-bit pixel number, 6-bit pixel data}.
- Pixel number = {row[8:0], col[7:0]}, i.e. a 256-pixel row stride.

---
 rtl/fb_rect_writer.sv | 174 +++++++++++++++++
 tb/tb_fb_rect_writer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_rect_writer.sv
// ============================================================================
// Module   : fb_rect_writer
// Brief    : Avalon-MM write master that fills a framebuffer rectangle with a
//            single colour index, one pixel word per accepted beat, raster order.
//            Optional clipping to the visible area: define FB_RECT_CLIP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_rect_writer #(
    parameter int FB_WIDTH  = 150,
    parameter int FB_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_x,
    input  logic [8:0]  cmd_y,
    input  logic [7:0]  cmd_w,
    input  logic [8:0]  cmd_h,
    input  logic [5:0]  cmd_color,
    output logic        av_chipselect,
    output logic        av_write,
    output logic [1:0]  av_address,
    output logic [31:0] av_writedata,
    input  logic        av_waitrequest,
    output logic        busy,
    output logic        done
);

`ifdef FB_RECT_CLIP_EN
    localparam bit c_clip_en = 1'b1;
`else
    localparam bit c_clip_en = 1'b0;
`endif

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_fin  = 2'd2;

    localparam logic [9:0] c_fb_width  = 10'(FB_WIDTH);
    localparam logic [9:0] c_fb_height = 10'(FB_HEIGHT);

    logic [1:0]  r_state;
    logic [7:0]  r_x;
    logic [8:0]  r_y;
    logic [7:0]  r_w;
    logic [8:0]  r_h;
    logic [5:0]  r_color;
    logic [7:0]  r_col_off;
    logic [8:0]  r_row_off;
    logic        r_cmd_ready;
    logic        r_av_write;
    logic        r_av_cs;
    logic [31:0] r_av_writedata;
    logic        r_busy;
    logic        r_done;

    logic [7:0]  w_eff_w;
    logic [8:0]  w_eff_h;
    logic        w_last_col;
    logic        w_last_row;

    function automatic logic [31:0] f_pixel_word(input logic [8:0] row,
                                                 input logic [7:0] col,
                                                 input logic [5:0] color);
        return {9'd0, row, col, color};
    endfunction

    // Effective size is fixed at accept time; without clipping it is the raw size.
    always_comb begin
        w_eff_w = cmd_w;
        w_eff_h = cmd_h;
        if (c_clip_en) begin
            if ({2'b00, cmd_x} >= c_fb_width)
                w_eff_w = 8'd0;
            else if ({2'b00, cmd_w} > c_fb_width - {2'b00, cmd_x})
                w_eff_w = 8'(c_fb_width - {2'b00, cmd_x});
            if ({1'b0, cmd_y} >= c_fb_height)
                w_eff_h = 9'd0;
            else if ({1'b0, cmd_h} > c_fb_height - {1'b0, cmd_y})
                w_eff_h = 9'(c_fb_height - {1'b0, cmd_y});
        end
    end

    assign w_last_col = (r_col_off == r_w - 8'd1);
    assign w_last_row = (r_row_off == r_h - 9'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= c_st_idle;
            r_x            <= 8'd0;
            r_y            <= 9'd0;
            r_w            <= 8'd0;
            r_h            <= 9'd0;
            r_color        <= 6'd0;
            r_col_off      <= 8'd0;
            r_row_off      <= 9'd0;
            r_cmd_ready    <= 1'b0;
            r_av_write     <= 1'b0;
            r_av_cs        <= 1'b0;
            r_av_writedata <= 32'd0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_x         <= cmd_x;
                        r_y         <= cmd_y;
                        r_w         <= w_eff_w;
                        r_h         <= w_eff_h;
                        r_color     <= cmd_color;
                        r_col_off   <= 8'd0;
                        r_row_off   <= 9'd0;
                        r_cmd_ready <= 1'b0;
                        if (w_eff_w == 8'd0 || w_eff_h == 9'd0) begin
                            r_state <= c_st_fin;
                            r_done  <= 1'b1;
                        end else begin
                            r_state        <= c_st_run;
                            r_busy         <= 1'b1;
                            r_av_write     <= 1'b1;
                            r_av_cs        <= 1'b1;
                            r_av_writedata <= f_pixel_word(cmd_y, cmd_x, cmd_color);
                        end
                    end
                end
                c_st_run: begin
                    // Next pixel word is prepared on acceptance so the bus output stays registered.
                    if (!av_waitrequest) begin
                        if (w_last_col) begin
                            r_col_off <= 8'd0;
                            if (w_last_row) begin
                                r_state    <= c_st_fin;
                                r_av_write <= 1'b0;
                                r_av_cs    <= 1'b0;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                            end else begin
                                r_row_off      <= r_row_off + 9'd1;
                                r_av_writedata <= f_pixel_word(r_y + r_row_off + 9'd1, r_x, r_color);
                            end
                        end else begin
                            r_col_off      <= r_col_off + 8'd1;
                            r_av_writedata <= f_pixel_word(r_y + r_row_off, r_x + r_col_off + 8'd1, r_color);
                        end
                    end
                end
                c_st_fin: begin
                    r_done      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign av_chipselect = r_av_cs;
    assign av_write      = r_av_write;
    assign av_address    = 2'b00;
    assign av_writedata  = r_av_writedata;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_fb_rect_writer.sv
// ============================================================================
// Module   : tb_fb_rect_writer
// Brief    : Randomised self-checking bench for fb_rect_writer against a
//            raster-order pixel model (honours FB_RECT_CLIP_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fb_rect_writer;

    localparam int FBW = 150;
    localparam int FBH = 480;

    typedef struct {
        int x;
        int y;
        int w;
        int h;
        int color;
    } rect_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_x = 8'd0;
    logic [8:0]  cmd_y = 9'd0;
    logic [7:0]  cmd_w = 8'd0;
    logic [8:0]  cmd_h = 9'd0;
    logic [5:0]  cmd_color = 6'd0;
    logic        av_chipselect;
    logic        av_write;
    logic [1:0]  av_address;
    logic [31:0] av_writedata;
    logic        av_waitrequest = 1'b0;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          g_expect_ready = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fb_rect_writer #(
        .FB_WIDTH (FBW),
        .FB_HEIGHT(FBH)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_x         (cmd_x),
        .cmd_y         (cmd_y),
        .cmd_w         (cmd_w),
        .cmd_h         (cmd_h),
        .cmd_color     (cmd_color),
        .av_chipselect (av_chipselect),
        .av_write      (av_write),
        .av_address    (av_address),
        .av_writedata  (av_writedata),
        .av_waitrequest(av_waitrequest),
        .busy          (busy),
        .done          (done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference: every pixel of the (optionally clipped) rectangle, column fastest.
    function automatic void build_expected(input rect_t r);
        int ew;
        int eh;
        ew = r.w;
        eh = r.h;
`ifdef FB_RECT_CLIP_EN
        ew = (r.x >= FBW) ? 0 : ((r.w < FBW - r.x) ? r.w : FBW - r.x);
        eh = (r.y >= FBH) ? 0 : ((r.h < FBH - r.y) ? r.h : FBH - r.y);
`endif
        exp_q.delete();
        for (int rr = 0; rr < eh; rr++)
            for (int cc = 0; cc < ew; cc++)
                exp_q.push_back({9'd0, 9'((r.y + rr) % 512), 8'((r.x + cc) % 256), 6'(r.color)});
    endfunction

    function automatic rect_t mk(input int x, input int y, input int w, input int h, input int c);
        rect_t r;
        r.x = x; r.y = y; r.w = w; r.h = h; r.color = c;
        return r;
    endfunction

    function automatic rect_t rand_rect();
        rect_t r;
        r.x = ($urandom_range(3) == 0) ? int'($urandom_range(160, 140)) : int'($urandom_range(255));
        r.y = ($urandom_range(3) == 0) ? int'($urandom_range(511, 470)) : int'($urandom_range(511));
        r.w = $urandom_range(12);
        r.h = $urandom_range(6);
        r.color = $urandom_range(63);
        return r;
    endfunction

    task automatic drive_cmd(input rect_t r);
        cmd_x     = 8'(r.x);
        cmd_y     = 9'(r.y);
        cmd_w     = 8'(r.w);
        cmd_h     = 9'(r.h);
        cmd_color = 6'(r.color);
    endtask

    task automatic wait_accept(output bit ok);
        int waits;
        waits = 0;
        ok = 1'b0;
        while (waits <= 50) begin
            @(negedge clk);
            if (g_expect_ready && waits == 0) chk("done_single_pulse", 32'(done), 32'd0);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            waits++;
            @(posedge clk); #1;
        end
        chk("accept_timeout", 32'(ok), 32'd1);
        if (ok && g_expect_ready) chk("ready_after_done", 32'(waits), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic run_cmd(input rect_t cur, input bit hold, input rect_t nxt,
                           input int stall_pct, input int stall_beat, input int stall_len);
        int cycles, beats, stalls, st_ctr, total;
        bit got_done, ok;
        build_expected(cur);
        total = exp_q.size();
        drive_cmd(cur);
        cmd_valid = 1'b1;
        wait_accept(ok);
        g_expect_ready = 1'b0;
        if (hold) drive_cmd(nxt);
        else cmd_valid = 1'b0;
        cycles = 0; beats = 0; stalls = 0; st_ctr = 0; got_done = 1'b0;
        while (ok && !got_done && cycles < 3000) begin
            if (beats == stall_beat && st_ctr < stall_len) av_waitrequest = 1'b1;
            else av_waitrequest = ($urandom_range(99) < stall_pct);
            @(negedge clk);
            cycles++;
            chk("cmd_ready_while_active", 32'(cmd_ready), 32'd0);
            if (done) begin
                got_done = 1'b1;
                chk("done_all_beats", 32'(beats), 32'(total));
                chk("done_busy", 32'(busy), 32'd0);
                chk("done_write", 32'(av_write), 32'd0);
                chk("done_latency", 32'(cycles), 32'(beats + stalls + 1));
            end else begin
                chk("busy", 32'(busy), 32'd1);
                chk("av_write", 32'(av_write), 32'd1);
                chk("av_chipselect", 32'(av_chipselect), 32'd1);
                chk("av_address", 32'(av_address), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("write_beyond_rect", 32'(beats + 1), 32'(total));
                end else begin
                    chk("writedata", av_writedata, exp_q[0]);
                    if (av_waitrequest) begin
                        stalls++;
                        if (beats == stall_beat) st_ctr++;
                    end else begin
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
            end
            if (!got_done) begin
                @(posedge clk); #1;
            end
        end
        if (ok) chk("done_timeout", 32'(got_done), 32'd1);
        @(posedge clk); #1;
        av_waitrequest = 1'b0;
        if (!hold) cmd_valid = 1'b0;
        g_expect_ready = ok && got_done;
    endtask

    task automatic run_mid_reset();
        int beats;
        bit ok;
        rect_t r;
        r = mk(5, 5, 10, 10, 7);
        build_expected(r);
        drive_cmd(r);
        cmd_valid = 1'b1;
        wait_accept(ok);
        cmd_valid = 1'b0;
        g_expect_ready = 1'b0;
        beats = 0;
        for (int i = 0; i < 20 && beats < 7; i++) begin
            @(negedge clk);
            chk("mid_no_done", 32'(done), 32'd0);
            if (av_write && exp_q.size() != 0) begin
                chk("mid_writedata", av_writedata, exp_q[0]);
                void'(exp_q.pop_front());
                beats++;
            end
            if (beats < 7) begin
                @(posedge clk); #1;
            end
        end
        chk("mid_beats_before_reset", 32'(beats), 32'd7);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("mid_rst_av_write", 32'(av_write), 32'd0);
        chk("mid_rst_cs", 32'(av_chipselect), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_wdata", av_writedata, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rel_no_done", 32'(done), 32'd0);
        chk("mid_rel_no_write", 32'(av_write), 32'd0);
        @(posedge clk); #1;
        g_expect_ready = 1'b1;
    endtask

    initial begin
        rect_t cur, nxt, none;
        none = mk(0, 0, 0, 0, 0);

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_av_write", 32'(av_write), 32'd0);
        chk("rst_cs", 32'(av_chipselect), 32'd0);
        chk("rst_wdata", av_writedata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_cmd_ready_low", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rel_cmd_ready_high", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        g_expect_ready = 1'b1;

        run_cmd(mk(10, 20, 2, 2, 1), 1'b0, none, 0, -1, 0);
        run_cmd(mk(0, 0, 3, 1, 2), 1'b0, none, 0, 1, 3);
        run_cmd(mk(30, 40, 0, 5, 9), 1'b0, none, 0, -1, 0);
        run_cmd(mk(148, 479, 5, 3, 3), 1'b0, none, 0, -1, 0);
        run_cmd(mk(250, 510, 8, 4, 63), 1'b0, none, 20, -1, 0);
        run_mid_reset();
        run_cmd(mk(12, 34, 1, 1, 44), 1'b0, none, 0, -1, 0);

        run_cmd(mk(1, 2, 3, 2, 5), 1'b1, mk(7, 8, 2, 3, 6), 0, -1, 0);
        run_cmd(mk(7, 8, 2, 3, 6), 1'b0, none, 30, -1, 0);

        cur = rand_rect();
        for (int i = 0; i < 40; i++) begin
            bit hold;
            nxt = rand_rect();
            hold = (i < 39) && ($urandom_range(1) == 1);
            run_cmd(cur, hold, nxt, 25, -1, 0);
            cur = nxt;
        end

        @(negedge clk);
        chk("final_idle_ready", 32'(cmd_ready), 32'd1);
        chk("final_idle_done", 32'(done), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
